bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-state bus arbiter: the CPU wins unless it has just been preempted, and devices are served round-robin.
// Every access takes WAIT_STATES+1 cycles and is acknowledged with mem_ack. A tenure ends after MAX_BURST acks if another master is waiting.
module bus_arbiter #(
  parameter int NUM_DEV     = 4,
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_bus_request,
  input  logic [NUM_DEV-1:0] dev_req,
  output logic               cpu_grant,
  output logic [NUM_DEV-1:0] dev_grant,
  output logic               mem_ack,
  output logic               bus_busy,
  output logic [3:0]         owner
);

  localparam int PW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               cpu_grant_q, cpu_grant_d;
  logic [NUM_DEV-1:0] dev_grant_q, dev_grant_d;
  logic               mem_ack_q, mem_ack_d;
  logic               bus_busy_q, bus_busy_d;
  logic [3:0]         owner_q, owner_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic               yield_q, yield_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]         hold_q, hold_d;

  logic               dev_found;
  logic [PW-1:0]      dev_pick;
  logic [PW-1:0]      idx;
  logic               owner_req;
  logic               other_req;
  logic               ack_now;
  logic [7:0]         burst_inc;

  // First requesting device after the last one granted, wrapping around.
  always_comb begin
    dev_found = 1'b0;
    dev_pick  = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_DEV);
      if (!dev_found && dev_req[idx]) begin
        dev_found = 1'b1;
        dev_pick  = idx;
      end
    end
  end

  always_comb begin
    owner_req = cpu_grant_q ? cpu_bus_request : (|(dev_req & dev_grant_q));
    other_req = cpu_grant_q ? dev_found
                            : (cpu_bus_request | (|(dev_req & ~dev_grant_q)));
    ack_now   = (wait_cnt_q == 4'(WAIT_STATES));
    burst_inc = (burst_cnt_q == 8'(MAX_BURST)) ? burst_cnt_q : burst_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    cpu_grant_d = cpu_grant_q;
    dev_grant_d = dev_grant_q;
    mem_ack_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    yield_d     = yield_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;

    case (state_q)
      IDLE: begin
        if (!dev_found) begin
          yield_d = 1'b0;
        end
        if (hold_q != 2'd0) begin
          // Post-reset quiet time: requests seen here are not arbitrated.
          hold_d = hold_q - 2'd1;
        end else if (cpu_bus_request || dev_found) begin
          state_d     = GRANT;
          wait_cnt_d  = 4'd0;
          burst_cnt_d = 8'd0;
          mem_ack_d   = (WAIT_STATES == 0);
          if (cpu_bus_request && !(yield_q && dev_found)) begin
            cpu_grant_d = 1'b1;
          end else begin
            dev_grant_d           = '0;
            dev_grant_d[dev_pick] = 1'b1;
            rr_ptr_d              = dev_pick;
            yield_d               = 1'b0;
          end
        end
      end

      GRANT: begin
        if (!owner_req) begin
          state_d     = IDLE;
          cpu_grant_d = 1'b0;
          dev_grant_d = '0;
        end else if (ack_now) begin
          wait_cnt_d  = 4'd0;
          burst_cnt_d = burst_inc;
          if ((burst_inc == 8'(MAX_BURST)) && other_req) begin
            state_d     = IDLE;
            cpu_grant_d = 1'b0;
            dev_grant_d = '0;
            if (cpu_grant_q) begin
              yield_d = 1'b1;
            end
          end else begin
            mem_ack_d = (WAIT_STATES == 0);
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          mem_ack_d  = ((wait_cnt_q + 4'd1) == 4'(WAIT_STATES));
        end
      end

      default: begin
        state_d     = IDLE;
        cpu_grant_d = 1'b0;
        dev_grant_d = '0;
      end
    endcase
  end

  always_comb begin
    owner_d = 4'd0;
    if (cpu_grant_d) begin
      owner_d = 4'd1;
    end
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_grant_d[i]) begin
        owner_d = 4'(i + 2);
      end
    end
    bus_busy_d = cpu_grant_d | (|dev_grant_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_grant_q <= 1'b0;
      dev_grant_q <= '0;
      mem_ack_q   <= 1'b0;
      bus_busy_q  <= 1'b0;
      owner_q     <= 4'd0;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 8'd0;
      yield_q     <= 1'b0;
      rr_ptr_q    <= PW'(NUM_DEV - 1);
      hold_q      <= 2'd2;
    end else begin
      state_q     <= state_d;
      cpu_grant_q <= cpu_grant_d;
      dev_grant_q <= dev_grant_d;
      mem_ack_q   <= mem_ack_d;
      bus_busy_q  <= bus_busy_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      yield_q     <= yield_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign cpu_grant = cpu_grant_q;
  assign dev_grant = dev_grant_q;
  assign mem_ack   = mem_ack_q;
  assign bus_busy  = bus_busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a random soak.
// Each cycle's expected outputs come from a tenure-level reference model and are queued for a separate monitor.
module tb_bus_arbiter;

  localparam int NDEV  = 4;
  localparam int WS    = 1;
  localparam int MB    = 2;
  localparam int BOUND = (NDEV + 1) * (MB * (WS + 1) + 1);
  localparam int HIST  = 16384;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cpu_bus_request = 1'b0;
  logic [NDEV-1:0] dev_req = '0;
  logic            cpu_grant;
  logic [NDEV-1:0] dev_grant;
  logic            mem_ack;
  logic            bus_busy;
  logic [3:0]      owner;

  bus_arbiter #(.NUM_DEV(NDEV), .WAIT_STATES(WS), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .cpu_bus_request(cpu_bus_request), .dev_req(dev_req),
    .cpu_grant(cpu_grant), .dev_grant(dev_grant), .mem_ack(mem_ack),
    .bus_busy(bus_busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic            cpu;
    logic [NDEV-1:0] dev;
    logic            ack;
    logic            busy;
    logic [3:0]      own;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   own_hist [HIST];
  int   ack_hist [HIST];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: owner id (0 none, 1 CPU, 2+i device i), index of the current
  // cycle within the tenure, acks completed so far, yield flag, last device served.
  int m_own = 0, m_j = 0, m_acks = 0, m_last = NDEV - 1, m_hold = 2;
  bit m_yield = 0, m_ack = 0;

  task automatic model_step(input bit rst, input bit cpu, input bit [NDEV-1:0] dev);
    bit any_dev, oreq, others, found;
    any_dev = (dev != 0);
    if (rst) begin
      m_own = 0; m_j = 0; m_acks = 0; m_yield = 0; m_last = NDEV - 1; m_hold = 2; m_ack = 0;
    end else if (m_own == 0) begin
      m_ack = 0;
      if (!any_dev) m_yield = 0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (cpu || any_dev) begin
        if (cpu && !(m_yield && any_dev)) begin
          m_own = 1;
        end else begin
          found = 0;
          for (int k = 1; k <= NDEV; k++) begin
            if (!found && dev[(m_last + k) % NDEV]) begin
              found = 1;
              m_own = 2 + (m_last + k) % NDEV;
            end
          end
          m_last = m_own - 2;
          m_yield = 0;
        end
        m_j = 1; m_acks = 0;
        m_ack = (m_j % (WS + 1) == 0);
      end
    end else begin
      if (m_own == 1) oreq = cpu;
      else oreq = dev[m_own - 2];
      if (!oreq) begin
        m_own = 0; m_ack = 0;
      end else if (m_ack) begin
        m_acks = (m_acks < MB) ? m_acks + 1 : MB;
        if (m_own == 1) others = any_dev;
        else others = cpu || ((dev & ~(NDEV'(1) << (m_own - 2))) != 0);
        if (m_acks == MB && others) begin
          if (m_own == 1) m_yield = 1;
          m_own = 0; m_ack = 0;
        end else begin
          m_j++;
          m_ack = (m_j % (WS + 1) == 0);
        end
      end else begin
        m_j++;
        m_ack = (m_j % (WS + 1) == 0);
      end
    end
  endtask

  task automatic step(input bit rst, input bit cpu, input bit [NDEV-1:0] dev);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    cpu_bus_request = cpu;
    dev_req = dev;
    model_step(rst, cpu, dev);
    e.cyc  = cyc + 1;
    e.cpu  = (m_own == 1);
    e.dev  = (m_own >= 2) ? (NDEV'(1) << (m_own - 2)) : '0;
    e.ack  = m_ack;
    e.busy = (m_own != 0);
    e.own  = 4'(m_own);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit rst, input bit cpu, input bit [NDEV-1:0] dev);
    for (int i = 0; i < n; i++) step(rst, cpu, dev);
  endtask

  // Monitor: compares whenever an expectation for the present cycle is queued.
  initial begin
    exp_t e;
    int prev_own;
    int wt [NDEV+1];
    logic [NDEV:0] rq;
    prev_own = 0;
    for (int r = 0; r <= NDEV; r++) wt[r] = 0;
    forever begin
      @(negedge clk);
      if (cyc < HIST) begin
        own_hist[cyc] = int'(owner);
        ack_hist[cyc] = int'(mem_ack);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("cpu_grant", 32'(cpu_grant), 32'(e.cpu));
        chk("dev_grant", 32'(dev_grant), 32'(e.dev));
        chk("mem_ack", 32'(mem_ack), 32'(e.ack));
        chk("bus_busy", 32'(bus_busy), 32'(e.busy));
        chk("owner", 32'(owner), 32'(e.own));
        chk("grant_onehot", 32'($countones({cpu_grant, dev_grant}) <= 1), 32'd1);
        chk("turnaround", 32'(prev_own != 0 && owner != 0 && int'(owner) != prev_own), 32'd0);
        rq = {dev_req, cpu_bus_request};
        for (int r = 0; r <= NDEV; r++) begin
          if (!reset && rq[r] && int'(owner) != r + 1) begin
            wt[r]++;
          end else begin
            if (wt[r] > 0) chk("wait_bound", 32'(wt[r] <= BOUND), 32'd1);
            wt[r] = 0;
          end
        end
      end
      prev_own = int'(owner);
    end
  end

  initial begin
    int t0;
    int s2_own [12] = '{2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 2, 2};
    int s3_own [12] = '{1, 1, 1, 1, 0, 3, 3, 3, 3, 0, 1, 1};
    int cnt [NDEV+1];
    bit lvl [NDEV+1];
    bit [NDEV-1:0] dv;

    run(3, 1, 0, '0);
    run(4, 0, 0, '0);

    // CPU alone: grant from the next cycle, ack every second cycle, never preempted.
    step(0, 1, '0); t0 = cyc;
    run(8, 0, 1, '0);
    run(3, 0, 0, '0);
    for (int k = 1; k <= 8; k++) begin
      chk("s1_owner", 32'(own_hist[t0 + k]), 32'd1);
      chk("s1_ack", 32'(ack_hist[t0 + k]), 32'(k % 2 == 0));
    end

    // Devices 0 and 2 alternate with one idle cycle between tenures.
    step(0, 0, 4'b0101); t0 = cyc;
    run(13, 0, 0, 4'b0101);
    run(3, 0, 0, '0);
    for (int k = 1; k <= 12; k++) chk("s2_owner", 32'(own_hist[t0 + k]), 32'(s2_own[k-1]));

    // CPU and device 1 together: CPU first, then device 1 after the CPU yields.
    step(0, 1, 4'b0010); t0 = cyc;
    run(12, 0, 1, 4'b0010);
    run(3, 0, 0, '0);
    for (int k = 1; k <= 12; k++) chk("s3_owner", 32'(own_hist[t0 + k]), 32'(s3_own[k-1]));

    // Owner abandons its access mid-wait while device 3 is waiting.
    step(0, 0, 4'b0100); t0 = cyc;
    run(4, 0, 0, 4'b1000);
    run(3, 0, 0, '0);
    chk("s4_owner_dev2", 32'(own_hist[t0 + 1]), 32'd4);
    chk("s4_no_ack", 32'(ack_hist[t0 + 1] | ack_hist[t0 + 2]), 32'd0);
    chk("s4_idle", 32'(own_hist[t0 + 2]), 32'd0);
    chk("s4_owner_dev3", 32'(own_hist[t0 + 3]), 32'd5);

    // One-cycle reset in the middle of a device tenure.
    step(0, 0, 4'b0011); t0 = cyc;
    step(0, 0, 4'b0011);
    step(1, 0, 4'b0011);
    run(5, 0, 0, 4'b0011);
    run(3, 0, 0, '0);
    chk("s5_pre_owner", 32'(own_hist[t0 + 1]), 32'd2);
    chk("s5_rst_owner", 32'(own_hist[t0 + 3]), 32'd0);
    chk("s5_rst_ack", 32'(ack_hist[t0 + 3]), 32'd0);
    chk("s5_quiet", 32'(own_hist[t0 + 4] | own_hist[t0 + 5]), 32'd0);
    chk("s5_rr_restart", 32'(own_hist[t0 + 6]), 32'd2);

    // Random soak: each request line holds its level for a random number of cycles.
    for (int r = 0; r <= NDEV; r++) begin
      cnt[r] = $urandom_range(1, 8);
      lvl[r] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int r = 0; r <= NDEV; r++) begin
        if (cnt[r] == 0) begin
          lvl[r] = ~lvl[r];
          cnt[r] = lvl[r] ? $urandom_range(1, 12) : $urandom_range(1, 8);
        end else begin
          cnt[r]--;
        end
      end
      for (int i = 0; i < NDEV; i++) dv[i] = lvl[i + 1];
      step(0, lvl[0], dv);
    end
    run(4, 0, 0, '0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
